// File: rtl/dsp_result_capture.sv
// dsp_result_capture: samples the DSP multiplier Z result a fixed number of
// cycles after each strobe, folds it into a MISR signature, queues it in a
// small FIFO and serialises queued words LSB-first as 5 bytes over a
// valid/ready stream.
module dsp_result_capture #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DEPTH   = 16,
  parameter logic [35:0] POLY    = 36'h8_0000_0057
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       strobe,
  input  logic [35:0]                z,
  input  logic                       clear,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic [35:0]                signature,
  output logic [15:0]                word_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  logic cap_en;

  // ---------------------------------------------------------------------------
  // Strobe delay line: cap_en marks the cycle in which z is valid.
  // ---------------------------------------------------------------------------
  if (LATENCY == 0) begin : g_no_delay
    assign cap_en = strobe;
  end else begin : g_delay
    logic [LATENCY-1:0] dly_q, dly_d;

    // Shift strobe in at bit 0; clear flushes any strobes in flight.
    always_comb begin
      dly_d    = '0;
      dly_d[0] = strobe;
      for (int unsigned i = 1; i < LATENCY; i++) dly_d[i] = dly_q[i-1];
      if (clear) dly_d = '0;
    end

    // Delay line register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) dly_q <= '0;
      else     dly_q <= dly_d;
    end

    assign cap_en = dly_q[LATENCY-1];
  end

  // ---------------------------------------------------------------------------
  // FIFO, flags and signature
  // ---------------------------------------------------------------------------
  logic [35:0]   mem_q [DEPTH];
  logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic [35:0]   sig_q, sig_d;
  logic [15:0]   wc_q, wc_d;
  logic          full, empty, push, pop;

  // full/empty come from registered pointers only, so a same-cycle pop never
  // frees a slot for a write into a full FIFO.
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign full       = (fifo_level == LW'(DEPTH));
  assign empty      = (fifo_level == '0);
  assign push       = cap_en && !full && !clear;

  // Pointer, flag, counter and MISR next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? LW'(1) : LW'(0));
    rd_ptr_d = rd_ptr_q + (pop  ? LW'(1) : LW'(0));
    ovf_d    = ovf_q | (cap_en && full);
    wc_d     = wc_q + (push ? 16'd1 : 16'd0);
    sig_d    = sig_q;
    if (cap_en)
      sig_d = {sig_q[34:0], 1'b0} ^ (sig_q[35] ? POLY : '0) ^ z;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      wc_d     = '0;
      sig_d    = '0;
    end
  end

  // Pointer, flag, counter and MISR registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      wc_q     <= '0;
      sig_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      wc_q     <= wc_d;
      sig_q    <= sig_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= z;
  end

  assign overflow   = ovf_q;
  assign signature  = sig_q;
  assign word_count = wc_q;

  // ---------------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [39:0] shreg_q, shreg_d;
  logic [2:0]  idx_q, idx_d;

  // Next-state: load from FIFO head when idle, or back-to-back after the
  // last byte of a word so there is no bubble between words.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    if (clear) begin
      state_d = IDLE;
      shreg_d = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = {4'h0, mem_q[rd_ptr_q[AW-1:0]]};
            idx_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx_q == 3'd4) begin
              if (!empty) begin
                pop     = 1'b1;
                shreg_d = {4'h0, mem_q[rd_ptr_q[AW-1:0]]};
                idx_d   = '0;
              end else begin
                shreg_d = '0;
                idx_d   = '0;
                state_d = IDLE;
              end
            end else begin
              shreg_d = shreg_q >> 8;
              idx_d   = idx_q + 3'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Serialiser state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_data  = shreg_q[7:0];

endmodule

// File: tb/tb_dsp_result_capture.sv
// Testbench for dsp_result_capture: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_dsp_result_capture;

  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 16;
  localparam logic [35:0] POLY  = 36'h8_0000_0057;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic [35:0] z;
  logic        clear;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        overflow;
  logic [35:0] signature;
  logic [15:0] word_count;

  dsp_result_capture #(
    .LATENCY(LAT),
    .DEPTH  (DEPTH),
    .POLY   (POLY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .strobe    (strobe),
    .z         (z),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .signature (signature),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: words waiting in a queue, one word in the serialiser.
  logic [35:0] m_q[$];
  bit          m_act;
  logic [39:0] m_word;
  int unsigned m_idx;
  bit          m_ovf;
  logic [35:0] m_sig;
  logic [15:0] m_wc;
  bit          m_hist[$];
  logic [7:0]  got_bytes[$];

  task automatic model_clear();
    m_q.delete();
    m_act = 0; m_word = '0; m_idx = 0;
    m_ovf = 0; m_sig = '0; m_wc = '0;
    m_hist.delete();
    for (int i = 0; i < int'(LAT); i++) m_hist.push_back(1'b0);
  endtask

  task automatic model_load();
    m_word = {4'h0, m_q.pop_front()};
    m_idx  = 0;
    m_act  = 1;
  endtask

  task automatic model_step(input bit s, input logic [35:0] zz, input bit rdy, input bit clr);
    bit cap, full, empty;
    if (LAT == 0) cap = s;
    else begin
      cap = m_hist.pop_front();
      m_hist.push_back(s);
    end
    if (clr) begin
      model_clear();
      return;
    end
    full  = (m_q.size() == int'(DEPTH));
    empty = (m_q.size() == 0);
    if (cap) begin
      m_sig = (m_sig << 1) ^ (m_sig[35] ? POLY : 36'h0) ^ zz;
      if (full) m_ovf = 1;
    end
    if (!m_act) begin
      if (!empty) model_load();
    end else if (rdy) begin
      if (m_idx == 4) begin
        if (!empty) model_load();
        else m_act = 0;
      end else m_idx++;
    end
    if (cap && !full) begin
      m_q.push_back(zz);
      m_wc++;
    end
  endtask

  task automatic check_outputs();
    logic [39:0] sh;
    check("out_valid", 64'(out_valid), 64'(m_act));
    if (m_act) begin
      sh = m_word >> (8 * m_idx);
      check("out_data", 64'(out_data), 64'(sh[7:0]));
    end
    check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("signature", 64'(signature), 64'(m_sig));
    check("word_count", 64'(word_count), 64'(m_wc));
  endtask

  // One clock cycle: drive, check pre-edge state, log handshake, advance model.
  task automatic cycle(input bit s, input logic [35:0] zz, input bit rdy, input bit clr);
    strobe = s; z = zz; out_ready = rdy; clear = clr;
    #1;
    check_outputs();
    if (out_valid && out_ready) got_bytes.push_back(out_data);
    @(posedge clk);
    model_step(s, zz, rdy, clr);
    @(negedge clk);
  endtask

  task automatic check_word_bytes(input string tag, input logic [35:0] w);
    logic [39:0] ww;
    ww = {4'h0, w};
    check({tag, "_nbytes"}, 64'(got_bytes.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_bytes.size()) check({tag, "_byte"}, 64'(got_bytes[i]), 64'(ww[8*i +: 8]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  logic [35:0] w5 [4];
  logic [63:0] r;

  initial begin
    rst = 1; strobe = 0; z = '0; clear = 0; out_ready = 0;
    model_clear();
    repeat (2) @(negedge clk);
    // Reset state
    check("rst_out_data", 64'(out_data), 64'd0);
    check_outputs();
    rst = 0;

    // 1: single word, LSB-first bytes
    got_bytes.delete();
    cycle(1, '0, 1, 0);
    cycle(0, 36'h9_8765_4321, 1, 0);
    repeat (8) cycle(0, '0, 1, 0);
    check_word_bytes("t1", 36'h9_8765_4321);
    check("t1_wc", 64'(word_count), 64'd1);

    // 2: backpressure holds byte 0 stable
    cycle(1, '0, 0, 0);
    cycle(0, 36'h9_8765_4321, 0, 0);
    cycle(0, '0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t2_hold_valid", 64'(out_valid), 64'd1);
      check("t2_hold_data", 64'(out_data), 64'h21);
      cycle(0, '0, 0, 0);
    end
    got_bytes.delete();
    repeat (8) cycle(0, '0, 1, 0);
    check_word_bytes("t2", 36'h9_8765_4321);

    // 3: overflow with 18 back-to-back captures
    cycle(0, '0, 1, 1);
    for (int i = 0; i <= 18; i++)
      cycle(i < 18, (i == 0) ? 36'h0 : 36'(i - 1), 0, 0);
    check("t3_level", 64'(fifo_level), 64'd16);
    check("t3_ovf", 64'(overflow), 64'd1);
    check("t3_wc", 64'(word_count), 64'd17);
    got_bytes.delete();
    repeat (100) cycle(0, '0, 1, 0);
    check("t3_nbytes", 64'(got_bytes.size()), 64'd85);
    for (int k = 0; k < 17; k++) begin
      logic [39:0] w;
      w = '0;
      for (int b = 0; b < 5; b++)
        if (5 * k + b < got_bytes.size()) w[8*b +: 8] = got_bytes[5*k + b];
      check("t3_word", 64'(w), 64'(k));
    end

    // 4: signature arithmetic
    cycle(0, '0, 1, 1);
    cycle(1, '0, 1, 0);
    cycle(1, 36'h1, 1, 0);
    cycle(0, 36'h1, 1, 0);
    check("t4_sig3", 64'(signature), 64'h3);
    cycle(0, '0, 1, 1);
    cycle(1, '0, 1, 0);
    cycle(1, 36'h8_0000_0000, 1, 0);
    cycle(0, 36'h0, 1, 0);
    check("t4_sigpoly", 64'(signature), 64'(POLY));
    repeat (14) cycle(0, '0, 1, 0);

    // 5: clear mid-word with words queued
    w5[0] = 36'h0_1111_1111; w5[1] = 36'h2_2222_2222;
    w5[2] = 36'h3_3333_3333; w5[3] = 36'h4_4444_4444;
    cycle(0, '0, 1, 1);
    cycle(1, '0, 0, 0);
    cycle(1, w5[0], 0, 0);
    cycle(1, w5[1], 0, 0);
    cycle(1, w5[2], 0, 0);
    cycle(0, w5[3], 0, 0);
    repeat (2) cycle(0, '0, 1, 0);
    check("t5_level_before", 64'(fifo_level), 64'd3);
    cycle(0, '0, 0, 1);
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_level", 64'(fifo_level), 64'd0);
    check("t5_ovf", 64'(overflow), 64'd0);
    check("t5_sig", 64'(signature), 64'd0);
    got_bytes.delete();
    cycle(1, '0, 1, 0);
    cycle(0, 36'h1_2345_6789, 1, 0);
    repeat (8) cycle(0, '0, 1, 0);
    check_word_bytes("t5", 36'h1_2345_6789);

    // 6: asynchronous reset mid-SEND
    cycle(1, '0, 0, 0);
    cycle(0, 36'h5_AAAA_5555, 0, 0);
    cycle(0, '0, 0, 0);
    check("t6_in_send", 64'(out_valid), 64'd1);
    #2 rst = 1;
    #1;
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_data", 64'(out_data), 64'd0);
    check("t6_level", 64'(fifo_level), 64'd0);
    check("t6_sig", 64'(signature), 64'd0);
    check("t6_wc", 64'(word_count), 64'd0);
    check("t6_ovf", 64'(overflow), 64'd0);
    model_clear();
    @(negedge clk);
    rst = 0;
    got_bytes.delete();
    cycle(1, '0, 1, 0);
    cycle(0, 36'h6_0102_0304, 1, 0);
    repeat (8) cycle(0, '0, 1, 0);
    check_word_bytes("t6", 36'h6_0102_0304);

    // Randomized traffic with varying backpressure and rare clears
    for (int blk = 0; blk < 20; blk++) begin
      int unsigned rdy_pct, stb_pct;
      rdy_pct = $urandom_range(0, 100);
      stb_pct = $urandom_range(5, 80);
      for (int i = 0; i < 100; i++) begin
        r = {$urandom(), $urandom()};
        cycle($urandom_range(0, 99) < stb_pct, r[35:0],
              $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 199) == 0);
      end
    end
    repeat (150) cycle(0, '0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
